// File: rtl/lease_lookup_engine_pkg.sv
// Shared definitions for the lease lookup engine: table-select codes, flush FSM
// encoding and maximal-length Fibonacci LFSR tap masks for widths 4..16.
package lease_lookup_engine_pkg;

  typedef enum logic [1:0] {
    TBL_REF    = 2'b00,
    TBL_LEASE0 = 2'b01,
    TBL_LEASE1 = 2'b10,
    TBL_PROB   = 2'b11
  } tbl_sel_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Bit k of the mask set means stage k+1 feeds the XOR.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0110;
    endcase
  endfunction

endpackage

// File: rtl/lease_lfsr.sv
// Fibonacci LFSR used as the lease0/lease1 random source; loads SEED on reset
// and shifts once per cycle with en high.
module lease_lfsr
  import lease_lookup_engine_pkg::*;
#(
  parameter int               WIDTH = 9,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  logic feedback;
  assign feedback = ^(value & TAPS);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     value <= SEED;
    else if (en) value <= {value[WIDTH-2:0], feedback};
  end

endmodule

// File: rtl/lease_lookup_engine.sv
// Two-stage lease lookup: associative match on stored reference addresses, then
// a probabilistic pick between two leases. Optional counters: LEASE_LOOKUP_STATS_EN.
module lease_lookup_engine
  import lease_lookup_engine_pkg::*;
#(
  parameter int N_ENTRIES         = 64,
  parameter int BW_REF_ADDR       = 30,
  parameter int BW_LEASE_REGISTER = 16,
  parameter int BW_PERCENTAGE     = 9,
  parameter int DEFAULT_LEASE     = 1
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [$clog2(N_ENTRIES)+1:0]   addr_i,
  input  logic                           wren_i,
  input  logic                           rmen_i,
  input  logic [31:0]                    data_i,
  input  logic                           flush_i,
  output logic                           busy_o,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [BW_REF_ADDR-1:0]         search_addr_i,
  output logic                           rsp_valid_o,
  output logic                           hit_o,
  output logic [BW_LEASE_REGISTER-1:0]   lease_o,
  output logic                           lease_sel_o
`ifdef LEASE_LOOKUP_STATS_EN
  ,
  output logic [31:0]                    hit_count_o,
  output logic [31:0]                    miss_count_o
`endif
);

  localparam int IDX_W  = $clog2(N_ENTRIES);
  localparam int ADDR_W = IDX_W + 2;
  localparam logic [BW_LEASE_REGISTER-1:0] MISS_LEASE = BW_LEASE_REGISTER'(DEFAULT_LEASE);
  localparam logic [IDX_W-1:0]             LAST_IDX   = IDX_W'(N_ENTRIES - 1);

  logic [BW_REF_ADDR-1:0]       ref_mem    [N_ENTRIES];
  logic [BW_LEASE_REGISTER-1:0] lease0_mem [N_ENTRIES];
  logic [BW_LEASE_REGISTER-1:0] lease1_mem [N_ENTRIES];
  logic [BW_PERCENTAGE-1:0]     prob_mem   [N_ENTRIES];
  logic [N_ENTRIES-1:0]         valid_q;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] flush_cnt_q;
  logic             flush_start;

  tbl_sel_e         cfg_tbl;
  logic [IDX_W-1:0] cfg_idx;
  logic             cfg_open, wr_ref, rm_ref;

  logic                     accept;
  logic                     lookup_hit;
  logic [IDX_W-1:0]         lookup_idx;
  logic [BW_PERCENTAGE-1:0] lfsr_value;

  logic                         s1_valid, s1_hit;
  logic [IDX_W-1:0]             s1_idx;
  logic [BW_PERCENTAGE-1:0]     s1_rand;
  logic                         sel_d;
  logic [BW_LEASE_REGISTER-1:0] lease_d;

  assign cfg_tbl  = tbl_sel_e'(addr_i[ADDR_W-1 -: 2]);
  assign cfg_idx  = addr_i[IDX_W-1:0];
  // Configuration is only honoured outside the flush sweep.
  assign cfg_open = (state_q == ST_IDLE);
  assign wr_ref   = cfg_open && wren_i && (cfg_tbl == TBL_REF);
  assign rm_ref   = cfg_open && rmen_i && (cfg_tbl == TBL_REF);

  assign busy_o      = (state_q == ST_FLUSH);
  assign req_ready_o = !busy_o;
  assign accept      = req_valid_i && req_ready_o;

  // NOTE: table payloads carry no reset; only valid_q gates their use, which
  // keeps them as plain RAM-style storage.
  always_ff @(posedge clock_i) begin
    if (cfg_open && wren_i) begin
      case (cfg_tbl)
        TBL_REF:    ref_mem[cfg_idx]    <= data_i[BW_REF_ADDR+1:2];
        TBL_LEASE0: lease0_mem[cfg_idx] <= data_i[BW_LEASE_REGISTER-1:0];
        TBL_LEASE1: lease1_mem[cfg_idx] <= data_i[BW_LEASE_REGISTER-1:0];
        default:    prob_mem[cfg_idx]   <= data_i[BW_PERCENTAGE-1:0];
      endcase
    end
  end

  // Remove wins over write, so wren+rmen stores the address but leaves it invalid.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                  valid_q              <= '0;
    else if (state_q == ST_FLUSH) valid_q[flush_cnt_q] <= 1'b0;
    else if (rm_ref)              valid_q[cfg_idx]     <= 1'b0;
    else if (wr_ref)              valid_q[cfg_idx]     <= 1'b1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= (state_q == ST_FLUSH) ? flush_cnt_q + 1'b1 : '0;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    flush_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d     = ST_FLUSH;
          flush_start = 1'b1;
        end
      end
      default: begin
        if (flush_cnt_q == LAST_IDX) state_d = ST_IDLE;
      end
    endcase
  end

  lease_lfsr #(
    .WIDTH (BW_PERCENTAGE)
  ) u_lfsr (
    .clk   (clock_i),
    .rst   (reset_i),
    .en    (accept),
    .value (lfsr_value)
  );

  // NOTE: combinational logic uses blocking assignments; scanning downwards
  // lets the lowest matching index be the last one written.
  always_comb begin
    lookup_hit = 1'b0;
    lookup_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (ref_mem[i] == search_addr_i)) begin
        lookup_hit = 1'b1;
        lookup_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_idx   <= '0;
      s1_rand  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_hit  <= lookup_hit;
        s1_idx  <= lookup_idx;
        s1_rand <= lfsr_value;
      end
    end
  end

  always_comb begin
    sel_d   = 1'b1;
    lease_d = MISS_LEASE;
    if (s1_hit) begin
      sel_d   = (s1_rand <= prob_mem[s1_idx]);
      lease_d = sel_d ? lease0_mem[s1_idx] : lease1_mem[s1_idx];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rsp_valid_o <= 1'b0;
      hit_o       <= 1'b0;
      lease_o     <= '0;
      lease_sel_o <= 1'b0;
    end else begin
      rsp_valid_o <= s1_valid;
      if (s1_valid) begin
        hit_o       <= s1_hit;
        lease_o     <= lease_d;
        lease_sel_o <= sel_d;
      end
    end
  end

`ifdef LEASE_LOOKUP_STATS_EN
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i || flush_start) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (rsp_valid_o) begin
      if (hit_o && (hit_count_o != '1))          hit_count_o  <= hit_count_o + 1'b1;
      else if (!hit_o && (miss_count_o != '1))   miss_count_o <= miss_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lease_lookup_engine.sv
// Directed bench for lease_lookup_engine with a response scoreboard; also checks
// the counters when LEASE_LOOKUP_STATS_EN is defined.
module tb_lease_lookup_engine;
  import lease_lookup_engine_pkg::*;

  localparam int N   = 64;
  localparam int AW  = 8;
  localparam int RW  = 30;
  localparam int LW  = 16;

  typedef struct {
    logic          hit;
    logic [LW-1:0] lease;
    logic          sel;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          wren, rmen, flush;
  logic [31:0]   data;
  logic          busy, req_valid, req_ready;
  logic [RW-1:0] search;
  logic          rsp_valid, hit, lease_sel;
  logic [LW-1:0] lease;
`ifdef LEASE_LOOKUP_STATS_EN
  logic [31:0]   hit_count, miss_count;
`endif

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;
  int   busy_cycles;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lease_lookup_engine dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .addr_i        (addr),
    .wren_i        (wren),
    .rmen_i        (rmen),
    .data_i        (data),
    .flush_i       (flush),
    .busy_o        (busy),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .search_addr_i (search),
    .rsp_valid_o   (rsp_valid),
    .hit_o         (hit),
    .lease_o       (lease),
    .lease_sel_o   (lease_sel)
`ifdef LEASE_LOOKUP_STATS_EN
    ,
    .hit_count_o   (hit_count),
    .miss_count_o  (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every visible response must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      check("rsp_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("rsp_hit", 32'(hit), 32'(e.hit));
        check("rsp_lease", 32'(lease), 32'(e.lease));
        check("rsp_sel", 32'(lease_sel), 32'(e.sel));
        check("rsp_latency", cyc, e.cyc);
        if (e.hit) exp_hits++;
        else       exp_misses++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wren      = 1'b0;
    rmen      = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic drive_req(input logic [RW-1:0] a, input logic e_hit,
                           input logic [LW-1:0] e_lease, input logic e_sel);
    exp_t e;
    req_valid = 1'b1;
    search    = a;
    e.hit     = e_hit;
    e.lease   = e_lease;
    e.sel     = e_sel;
    e.cyc     = cyc + 2;
    q.push_back(e);
  endtask

  task automatic drive_cfg(input logic wr, input logic rm, input tbl_sel_e t,
                           input int idx, input logic [31:0] d);
    wren = wr;
    rmen = rm;
    addr = {t, 6'(idx)};
    data = d;
  endtask

  task automatic lookup(input logic [RW-1:0] a, input logic e_hit,
                        input logic [LW-1:0] e_lease, input logic e_sel);
    drive_req(a, e_hit, e_lease, e_sel);
    step();
  endtask

  task automatic cfg_write(input tbl_sel_e t, input int idx, input logic [31:0] d);
    drive_cfg(1'b1, 1'b0, t, idx, d);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef LEASE_LOOKUP_STATS_EN
    step();
    check({tag, "_hit_count"}, hit_count, exp_hits);
    check({tag, "_miss_count"}, miss_count, exp_misses);
`else
    step();
`endif
  endtask

  initial begin
    rst = 1'b1; addr = '0; wren = 1'b0; rmen = 1'b0; flush = 1'b0;
    data = '0; req_valid = 1'b0; search = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_hit", 32'(hit), 0);
    check("reset_lease", 32'(lease), 0);
    check("reset_sel", 32'(lease_sel), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_ready", 32'(req_ready), 1);
    step();

    // Basic hit; first request after reset sees LFSR all-ones against prob=max.
    cfg_write(TBL_REF, 3, 32'h1000);
    cfg_write(TBL_LEASE0, 3, 50);
    cfg_write(TBL_LEASE1, 3, 7);
    cfg_write(TBL_PROB, 3, 32'h1FF);
    lookup(30'h400, 1'b1, 16'd50, 1'b1);
    drain();
    repeat (3) step();
    check("hold_rsp_valid", 32'(rsp_valid), 0);
    check("hold_hit", 32'(hit), 1);
    check("hold_lease", 32'(lease), 50);
    check("hold_sel", 32'(lease_sel), 1);

    // prob=0: the nonzero LFSR never selects lease0.
    cfg_write(TBL_PROB, 3, 0);
    for (int i = 0; i < 20; i++) lookup(30'h400, 1'b1, 16'd7, 1'b0);
    drain();

    // Same-edge lease write is visible to stage 2.
    drive_req(30'h400, 1'b1, 16'd9, 1'b0);
    drive_cfg(1'b1, 1'b0, TBL_LEASE1, 3, 9);
    step();
    drain();

    // Same-edge ref write is not visible to stage 1; the next lookup misses.
    drive_req(30'h400, 1'b1, 16'd9, 1'b0);
    drive_cfg(1'b1, 1'b0, TBL_REF, 3, 32'h2000);
    step();
    lookup(30'h400, 1'b0, 16'd1, 1'b1);
    drain();

    lookup(30'h999, 1'b0, 16'd1, 1'b1);
    drain();
    check_stats("after_miss");

    // Multiple matches: lowest index wins; remove and write+remove fall through.
    cfg_write(TBL_REF, 3, 32'h1000);
    cfg_write(TBL_REF, 2, 32'h1000);
    cfg_write(TBL_LEASE0, 2, 20);
    cfg_write(TBL_LEASE1, 2, 21);
    cfg_write(TBL_PROB, 2, 32'h1FF);
    cfg_write(TBL_REF, 5, 32'h1000);
    cfg_write(TBL_LEASE0, 5, 30);
    cfg_write(TBL_LEASE1, 5, 31);
    cfg_write(TBL_PROB, 5, 32'h1FF);
    lookup(30'h400, 1'b1, 16'd20, 1'b1);
    drain();
    drive_cfg(1'b0, 1'b1, TBL_REF, 2, 0);
    step();
    lookup(30'h400, 1'b1, 16'd9, 1'b0);
    drain();
    drive_cfg(1'b1, 1'b1, TBL_REF, 3, 32'h1000);
    step();
    lookup(30'h400, 1'b1, 16'd30, 1'b1);
    drain();

    // Flush sweep with one lookup in flight; writes and re-flush are dropped.
    drive_req(30'h400, 1'b1, 16'd30, 1'b1);
    flush = 1'b1;
    step();
    exp_hits    = 0;
    exp_misses  = 0;
    busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cycles++;
      if (i == 0) check("flush_ready_low", 32'(req_ready), 0);
      if (i == 5) drive_cfg(1'b1, 1'b0, TBL_REF, 10, 32'h3000);
      if (i == 6) wren = 1'b0;
      if (i == 10) flush = 1'b1;
      if (i == 11) flush = 1'b0;
    end
    wren  = 1'b0;
    flush = 1'b0;
    check("flush_busy_cycles", busy_cycles, N);
    check("flush_ready_after", 32'(req_ready), 1);
    lookup(30'h400, 1'b0, 16'd1, 1'b1);
    lookup(30'hC00, 1'b0, 16'd1, 1'b1);
    drain();
    check_stats("after_flush");

    // Back-to-back stream interrupted by reset.
    cfg_write(TBL_REF, 3, 32'h1000);
    for (int i = 0; i < 6; i++) lookup(30'h400, 1'b1, 16'd9, 1'b0);
    rst = 1'b1;
    q.delete();
    exp_hits   = 0;
    exp_misses = 0;
    #1;
    check("midreset_rsp_valid", 32'(rsp_valid), 0);
    check("midreset_hit", 32'(hit), 0);
    check("midreset_lease", 32'(lease), 0);
    check("midreset_sel", 32'(lease_sel), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step();
    check("post_reset_quiet", 32'(rsp_valid), 0);
    lookup(30'h400, 1'b0, 16'd1, 1'b1);
    drain();
    check_stats("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lease_lookup_engine.md
LEASE_LOOKUP_ENGINE -- requirements
Module: lease_lookup_engine

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 64, table depth (power of two, >=2).
REQ-002 SHALL have parameter BW_REF_ADDR, default 30, stored reference word-address width.
REQ-003 SHALL have parameter BW_LEASE_REGISTER, default 16, lease width.
REQ-004 SHALL have parameter BW_PERCENTAGE, default 9, lease0 probability and LFSR width (4..16).
REQ-005 SHALL have parameter DEFAULT_LEASE, default 1, lease returned on miss.
REQ-006 SHALL have ports: clock_i  in  1  sole clock (rising edge); reset_i  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: addr_i  in  CLOG2(N_ENTRIES)+2  config address, top 2 bits select table (00 ref, 01 lease0, 10 lease1, 11 prob); wren_i  in  1  config write; rmen_i  in  1  invalidate entry; data_i  in  32  config word.
REQ-008 SHALL have ports: flush_i  in  1  start invalidate-all sweep; busy_o  out  1  sweep active.
REQ-009 SHALL have ports: req_valid_i  in  1; req_ready_o  out  1; search_addr_i  in  BW_REF_ADDR  lookup word address.
REQ-010 SHALL have ports: rsp_valid_o  out  1; hit_o  out  1; lease_o  out  BW_LEASE_REGISTER  selected lease; lease_sel_o  out  1  1 = lease0 chosen.

Function
REQ-011 Ref-table write SHALL store data_i[BW_REF_ADDR+1:2] and set the entry valid; lease/prob writes store low bits of data_i.
REQ-012 wren_i and rmen_i together on ref table SHALL leave the entry invalid with the new address stored.
REQ-013 A request SHALL be accepted on a rising edge with req_valid_i & req_ready_o; req_ready_o = !busy_o.
REQ-014 Pipeline: stage 1 compares all valid entries, registers hit flag and lowest matching index; stage 2 reads lease0/lease1/prob at that index and registers outputs.
REQ-015 Latency SHALL be exactly 2 cycles; throughput one lookup per cycle; no response back-pressure.
REQ-016 Stage-1 compare SHALL use table contents before any same-edge write; stage-2 SHALL read lease arrays current in its cycle.
REQ-017 Multiple matches SHALL resolve to the lowest index.
REQ-018 Internal Fibonacci LFSR (width BW_PERCENTAGE, nonzero seed all-ones) SHALL advance once per accepted request.
REQ-019 On hit: lease_sel_o = (lfsr_sampled <= prob); lease_o = lease0 if selected else lease1; lfsr value is sampled at acceptance.
REQ-020 On miss: hit_o=0, lease_sel_o=1, lease_o=DEFAULT_LEASE.
REQ-021 Outputs hit_o/lease_o/lease_sel_o SHALL hold their last value while rsp_valid_o=0.
REQ-022 FSM states IDLE, FLUSH: IDLE->FLUSH on flush_i; FLUSH clears validbit[cnt] per cycle, cnt 0..N_ENTRIES-1, ->IDLE after last entry (N_ENTRIES cycles busy).
REQ-023 flush_i during FLUSH SHALL be ignored; config writes/removes during FLUSH SHALL be dropped.
REQ-024 Lookups in flight when FLUSH starts SHALL complete with stage-1 results.

Reset
REQ-025 reset_i SHALL asynchronously clear validbits, pipeline valids, outputs (rsp_valid_o=0, hit_o=0, lease_o=0, lease_sel_o=0), busy_o=0, FSM=IDLE, LFSR=all-ones.
REQ-026 Reset mid-flush SHALL abort the sweep; lease/prob arrays need not be cleared.

Configuration
REQ-027 Macro LEASE_LOOKUP_STATS_EN SHALL add outputs hit_count_o and miss_count_o (32 b, saturating, incremented at rsp_valid_o, cleared by reset and FLUSH entry).
REQ-028 Without LEASE_LOOKUP_STATS_EN those ports and counters SHALL not exist.

Structure
REQ-029 Shared package SHALL hold table-select codes, FSM state encoding, and LFSR tap table per width 4..16.
REQ-030 Sub-module lease_lfsr (width parameter, enable, seed) SHALL implement the LFSR.

Verification
REQ-031 Write ref[3]=0x1000, lease0=50, lease1=7, prob=max; lookup 0x400 -> 2 cycles later hit_o=1, lease_o=50, lease_sel_o=1.
REQ-032 Same entry prob=0; 20 lookups -> all lease_o=7, lease_sel_o=0.
REQ-033 Lookup unmapped 0x999 -> hit_o=0, lease_o=DEFAULT_LEASE; stats miss_count_o=1.
REQ-034 Entries 2 and 5 both 0x400, different leases -> entry 2 lease returned.
REQ-035 flush_i with N_ENTRIES=64 -> busy_o/req_ready_o low exactly 64 cycles; subsequent lookup of 0x400 misses.
REQ-036 Back-to-back lookups every cycle plus reset_i asserted mid-stream -> rsp_valid_o drops immediately, no stale response after reset release.
